ripple_count_monitor: RTL
=========================

# ripple_count_monitor

Synchronous consumer of a 4-bit ripple counter's output in the `clk` domain.
- Filters the ripple-settling glitches on the count bus.
- Converts each accepted change into a modulo-16 increment and accumulates it into a wider saturating total.
- Flags wrap-around and terminal count.
- Hands a snapshot of the total downstream over a valid/ready port on every wrap.

It sits directly after `ripple_carry_counter`, with `cnt_in` tied to the counter's `q`.

## Interface
- `CNT_W`, 4: width of the sampled count.
- `ACC_W`, 8: width of the accumulator and the snapshot.
- `STABLE_CYC`, 2: consecutive equal samples required to accept a value; range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `cnt_in`  in  CNT_W  count from the upstream ripple counter; may be transiently wrong while rippling.
- `clear`  in  1  synchronous: zeroes `acc`, `acc_ovf` and `rpt_lost`; returns to INIT.
- `acc`  out  ACC_W  running total of accepted increments, saturating.
- `acc_ovf`  out  1  sticky; set when saturation clips an addition.
- `wrap_pulse`  out  1  one-cycle pulse when an accepted value is below the previous accepted value.
- `tc_pulse`  out  1  one-cycle pulse when the value 2^CNT_W-1 is newly accepted.
- `rpt_data`  out  ACC_W  snapshot of `acc` taken on a wrap.
- `rpt_valid`  out  1  snapshot pending.
- `rpt_ready`  in  1  downstream accepts `rpt_data` when high together with `rpt_valid`.
- `rpt_lost`  out  1  sticky; a wrap occurred while a snapshot was still pending.

## Operation
- Every edge: `samp <= cnt_in`. `match = (cnt_in == samp)`.
- Stability counter `stab`:
  - cleared to 0 when `!match`;
  - otherwise incremented, saturating at STABLE_CYC.
- Value V is stable at an edge when `cnt_in` has equalled V on STABLE_CYC consecutive edges, including that edge.
  - For STABLE_CYC=1, every sample counts as stable.
- State machine, two states:
  - INIT (reset state):
    - first stable value is loaded into `last`;
    - no accumulation, no pulses;
    - go to TRACK.
  - TRACK: when a stable V differs from `last`, V is accepted:
    - `delta = (V - last) mod 2^CNT_W`, which is always in 1..15;
    - `acc <= min(acc + delta, 2^ACC_W-1)`; `acc_ovf` set if clipped;
    - `last <= V`;
    - `wrap_pulse` when V < `last`;
    - `tc_pulse` when V = 2^CNT_W-1.
  - A stable V equal to `last` causes no action.
  - `clear` forces INIT, from either state.
- Snapshot on each `wrap_pulse`:
  - if `rpt_valid` is low, or is being accepted this cycle: `rpt_data <= acc` post-update value, `rpt_valid <= 1`;
  - otherwise keep the old pending data and set `rpt_lost`.
- Handshake:
  - `rpt_valid` and `rpt_data` hold steady until `rpt_valid && rpt_ready`;
  - `rpt_valid` drops the edge after acceptance, unless a new snapshot loads on that same edge.
- `clear` does not drop a pending `rpt_valid`.
  - If `clear` and a wrap coincide, `clear` wins: no accumulation, no snapshot.
- Reset values:
  - `acc`=0, `acc_ovf`=0, `wrap_pulse`=0, `tc_pulse`=0;
  - `rpt_data`=0, `rpt_valid`=0, `rpt_lost`=0;
  - state=INIT, `samp`=0, `stab`=0, `last`=0.
- Reset asserted mid-operation drops any pending report.

## Timing
- V first present at edge k; with STABLE_CYC=S it is accepted at edge k+S-1.
  - `acc`, `last` and the pulses are visible after that edge.
  - With the default S=2: accepted at k+1.
- Pulses are registered and last exactly one cycle.
- Snapshot: `rpt_valid` rises after the same edge as `wrap_pulse`.
- No combinational path from inputs to outputs.
- The upstream counter must hold each value for at least S edges; faster changes are filtered and merged into later deltas.

## Structure
- Shared package `counter_pkg`:
  - `CNT_W`/`ACC_W` defaults;
  - state enum constants `ST_INIT`, `ST_TRACK`.
- One natural sub-module, `stable_filter`: the `samp`/`stab` logic, emitting `stable_vld` and `stable_val`.
- Accumulator, FSM and report register stay in the top.

## Test plan
- Reset, then hold `cnt_in`=3 → INIT loads `last`=3; `acc` stays 0; no pulses.
- Step `cnt_in` 3→4→5, each held 2 cycles → `acc`=2 after the second acceptance; no `wrap_pulse`.
- Glitch `cnt_in` 5→7 for 1 cycle, then 6 held → 7 ignored; `acc` +1 = 3.
- Step 14→15→0, each held 2 cycles, `rpt_ready`=0 →
  - `tc_pulse` on 15;
  - `wrap_pulse` on 0;
  - `rpt_valid`=1 with `rpt_data`=`acc`;
  - a second wrap before ready → `rpt_lost`=1 and `rpt_data` unchanged.
- Drive the total past 255 → `acc`=255, `acc_ovf`=1; then `clear` → `acc`=0, flags cleared, INIT.
- Assert `reset` while `rpt_valid`=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and FSM encoding for the ripple-counter consumer.
package counter_pkg;

    localparam int CNT_W_DEF      = 4;
    localparam int ACC_W_DEF      = 8;
    localparam int STABLE_CYC_DEF = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_t;

endpackage

// File: rtl/stable_filter.sv
// Glitch filter: a value is reported stable once it has been sampled on
// STABLE_CYC consecutive edges, the current edge included.
module stable_filter #(
    parameter int CNT_W      = 4,
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             stable_vld,
    output logic [CNT_W-1:0] stable_val
);

    localparam logic [2:0] STAB_MAX  = 3'(STABLE_CYC);
    localparam logic [2:0] STAB_NEED = 3'((STABLE_CYC >= 2) ? STABLE_CYC - 2 : 0);

    logic [CNT_W-1:0] samp;
    logic [2:0]       stab;
    logic             match;

    assign match      = (cnt_in == samp);
    assign stable_val = cnt_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp <= '0;
            stab <= '0;
        end else begin
            samp <= cnt_in;
            if (!match)
                stab <= '0;
            else if (stab < STAB_MAX)
                stab <= stab + 3'd1;
        end
    end

    // stab counts matches before this edge; this edge adds one more sample
    // and the first sample of the run is the mismatching one, hence S-2.
    generate
        if (STABLE_CYC <= 1) begin : g_pass
            assign stable_vld = 1'b1;
        end else begin : g_filt
            assign stable_vld = match && (stab >= STAB_NEED);
        end
    endgenerate

endmodule

// File: rtl/ripple_count_monitor.sv
// Accumulates filtered ripple-counter increments into a saturating total and
// reports a snapshot of the total over valid/ready on every wrap.
module ripple_count_monitor
    import counter_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clear,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf,
    output logic             wrap_pulse,
    output logic             tc_pulse,
    output logic [ACC_W-1:0] rpt_data,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             rpt_lost
);

    logic             stable_vld;
    logic [CNT_W-1:0] stable_val;

    stable_filter #(
        .CNT_W      (CNT_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filt (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .stable_vld (stable_vld),
        .stable_val (stable_val)
    );

    mon_state_t       state;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] delta;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             clip;
    logic             accept;
    logic             wrap;
    logic             tc;
    logic             snap_ok;

    always_comb begin
        delta   = stable_val - last;
        sum     = {1'b0, acc} + (ACC_W+1)'(delta);
        clip    = sum[ACC_W];
        acc_nxt = clip ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        accept  = (state == ST_TRACK) && stable_vld && (stable_val != last);
        wrap    = accept && (stable_val < last);
        tc      = accept && (stable_val == {CNT_W{1'b1}});
        snap_ok = !rpt_valid || rpt_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            last       <= '0;
            acc        <= '0;
            acc_ovf    <= 1'b0;
            wrap_pulse <= 1'b0;
            tc_pulse   <= 1'b0;
            rpt_data   <= '0;
            rpt_valid  <= 1'b0;
            rpt_lost   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            tc_pulse   <= 1'b0;
            if (rpt_valid && rpt_ready)
                rpt_valid <= 1'b0;

            // clear outranks any acceptance, but a pending report survives it
            if (clear) begin
                state    <= ST_INIT;
                acc      <= '0;
                acc_ovf  <= 1'b0;
                rpt_lost <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        if (stable_vld) begin
                            last  <= stable_val;
                            state <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (accept) begin
                            acc        <= acc_nxt;
                            last       <= stable_val;
                            tc_pulse   <= tc;
                            wrap_pulse <= wrap;
                            if (clip)
                                acc_ovf <= 1'b1;
                            if (wrap) begin
                                if (snap_ok) begin
                                    rpt_data  <= acc_nxt;
                                    rpt_valid <= 1'b1;
                                end else begin
                                    rpt_lost  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

endmodule
